// File: rtl/fixedpoint_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fixedpoint (package)
// Description : Q16.16 number type, limits and a saturating 34-bit add.
// Revision    : 1.0 - initial release
// ============================================================================
package fixedpoint;

    localparam int WIDTH     = 32;
    localparam int FRAC      = 16;
    localparam int ACC_WIDTH = WIDTH + 2;

    typedef logic signed [WIDTH-1:0]     number;
    typedef logic signed [ACC_WIDTH-1:0] acc_t;

    localparam number MAX = 32'sh7FFF_FFFF;
    localparam number MIN = 32'sh8000_0000;

    typedef struct packed {
        number value;
        logic  overflow;
    } sat_t;

    // Two guard bits keep the sum of three full-scale terms exact before clamping.
    function automatic sat_t sat_add(input acc_t acc, input number term);
        acc_t s;
        sat_t r;
        s = acc + acc_t'(term);
        if (s > acc_t'(MAX)) begin
            r.value    = MAX;
            r.overflow = 1'b1;
        end else if (s < acc_t'(MIN)) begin
            r.value    = MIN;
            r.overflow = 1'b1;
        end else begin
            r.value    = s[WIDTH-1:0];
            r.overflow = 1'b0;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dot3_accum.sv
`default_nettype none
// ============================================================================
// Module      : dot3_accum
// Description : Sums groups of three Q16.16 product terms with saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module dot3_accum
    import fixedpoint::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  in_valid,
    input  number prod,
    input  logic  clr,
    output number sum,
    output logic  out_valid,
    output logic  overflow,
    output logic  busy
);

    localparam logic [1:0] c_E0 = 2'd0;
    localparam logic [1:0] c_E1 = 2'd1;
    localparam logic [1:0] c_E2 = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    acc_t       r_acc;
    number      r_sum;
    logic       r_out_valid;
    logic       r_overflow;

    logic       w_accept;
    logic       w_load;
    logic       w_add;
    logic       w_fire;
    sat_t       w_sat;

    // clr outranks in_valid: a term presented together with clr is dropped.
    assign w_accept = in_valid && !clr;
    assign w_sat    = sat_add(r_acc, prod);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_E0;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (clr) begin
            w_next_state = c_E0;
        end else if (in_valid) begin
            case (r_state)
                c_E0:    w_next_state = c_E1;
                c_E1:    w_next_state = c_E2;
                default: w_next_state = c_E0;
            endcase
        end
    end

    always_comb begin
        w_load = 1'b0;
        w_add  = 1'b0;
        w_fire = 1'b0;
        busy   = 1'b0;
        case (r_state)
            c_E0: begin
                w_load = w_accept;
            end
            c_E1: begin
                w_add = w_accept;
                busy  = 1'b1;
            end
            default: begin
                w_fire = w_accept;
                busy   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_acc <= '0;
        end else if (w_load) begin
            r_acc <= acc_t'(prod);
        end else if (w_add) begin
            r_acc <= r_acc + acc_t'(prod);
        end else if (w_fire) begin
            r_acc <= '0;
        end
    end

    // Output stage is independent of clr so a completed group always emits its pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_overflow  <= 1'b0;
        end else if (w_fire) begin
            r_out_valid <= 1'b1;
            r_sum       <= w_sat.value;
            r_overflow  <= w_sat.overflow;
        end else begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_overflow  <= 1'b0;
        end
    end

    assign sum       = r_sum;
    assign out_valid = r_out_valid;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_dot3_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_dot3_accum
// Description : Self-checking bench: vector table, corner sequences, random run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dot3_accum;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] prod;
    logic        clr;
    logic [31:0] sum;
    logic        out_valid;
    logic        overflow;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    // Reference model: count of terms in the current group and their exact sum.
    int          m_n;
    longint      m_acc;
    logic        m_ov;
    logic [31:0] m_sum;
    logic        m_of;

    int          pulses;
    logic [31:0] last_sum;
    logic        last_of;

    typedef struct packed {
        logic [31:0] t0;
        logic [31:0] t1;
        logic [31:0] t2;
        logic [31:0] exp_sum;
        logic        exp_of;
    } vec_t;

    dot3_accum u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .prod      (prod),
        .clr       (clr),
        .sum       (sum),
        .out_valid (out_valid),
        .overflow  (overflow),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_step(input logic v, input logic [31:0] p,
                                       input logic c, input logic r);
        m_ov  = 1'b0;
        m_sum = 32'h0;
        m_of  = 1'b0;
        if (r || c) begin
            m_n   = 0;
            m_acc = 0;
        end else if (v) begin
            m_acc = (m_n == 0) ? longint'($signed(p)) : m_acc + longint'($signed(p));
            m_n++;
            if (m_n == 3) begin
                m_ov = 1'b1;
                if (m_acc > 64'sd2147483647) begin
                    m_sum = 32'h7FFF_FFFF;
                    m_of  = 1'b1;
                end else if (m_acc < -64'sd2147483648) begin
                    m_sum = 32'h8000_0000;
                    m_of  = 1'b1;
                end else begin
                    m_sum = m_acc[31:0];
                end
                m_n   = 0;
                m_acc = 0;
            end
        end
    endfunction

    // One clock: drive inputs, let the edge happen, compare every output to the model.
    task automatic cycle(input logic v, input logic [31:0] p, input logic c, input logic r);
        in_valid = v;
        prod     = p;
        clr      = c;
        rst      = r;
        @(posedge clk);
        #1;
        model_step(v, p, c, r);
        check("out_valid", {63'd0, out_valid}, {63'd0, m_ov});
        check("sum",       {32'd0, sum},       {32'd0, m_sum});
        check("overflow",  {63'd0, overflow},  {63'd0, m_of});
        check("busy",      {63'd0, busy},      {63'd0, (m_n != 0)});
        if (out_valid) begin
            pulses++;
            last_sum = sum;
            last_of  = overflow;
        end
        in_valid = 1'b0;
        clr      = 1'b0;
        rst      = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    vec_t vecs[8];

    initial begin
        m_n = 0; m_acc = 0; m_ov = 0; m_sum = 0; m_of = 0;
        pulses = 0; last_sum = 0; last_of = 0;
        in_valid = 0; prod = 0; clr = 0; rst = 1;

        vecs[0] = '{32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0006_0000, 1'b0};
        vecs[1] = '{32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_FFFF, 1'b1};
        vecs[2] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1};
        vecs[3] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFD_0000, 1'b0};
        vecs[4] = '{32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0001_8000, 1'b0};
        vecs[5] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFE, 1'b0};
        vecs[6] = '{32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1};
        vecs[7] = '{32'h7FFF_0000, 32'h0001_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b0};

        // Reset state
        cycle(1'b1, 32'h0001_0000, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_sum",       {32'd0, sum},       64'd0);
        check("rst_busy",      {63'd0, busy},      64'd0);
        check("rst_overflow",  {63'd0, overflow},  64'd0);

        // Vector table, back-to-back terms
        foreach (vecs[i]) begin
            cycle(1'b1, vecs[i].t0, 1'b0, 1'b0);
            cycle(1'b1, vecs[i].t1, 1'b0, 1'b0);
            check("vec_no_early_pulse", {63'd0, out_valid}, 64'd0);
            cycle(1'b1, vecs[i].t2, 1'b0, 1'b0);
            check("vec_out_valid", {63'd0, out_valid}, 64'd1);
            check("vec_sum",       {32'd0, sum},       {32'd0, vecs[i].exp_sum});
            check("vec_overflow",  {63'd0, overflow},  {63'd0, vecs[i].exp_of});
            idle(1);
            check("vec_pulse_one_cycle", {63'd0, out_valid}, 64'd0);
        end

        // Gaps of 2 and 5 idle cycles between terms
        pulses = 0;
        cycle(1'b1, 32'h0001_0000, 1'b0, 1'b0);
        check("gap_busy_after_1st", {63'd0, busy}, 64'd1);
        idle(2);
        check("gap_busy_idle", {63'd0, busy}, 64'd1);
        cycle(1'b1, 32'h0002_0000, 1'b0, 1'b0);
        idle(5);
        check("gap_busy_idle2", {63'd0, busy}, 64'd1);
        cycle(1'b1, 32'h0003_0000, 1'b0, 1'b0);
        check("gap_busy_done", {63'd0, busy}, 64'd0);
        idle(3);
        check("gap_pulses", pulses, 1);
        check("gap_sum", {32'd0, last_sum}, 64'h0006_0000);

        // Partial group discarded by clr
        pulses = 0;
        cycle(1'b1, 32'h0005_0000, 1'b0, 1'b0);
        cycle(1'b1, 32'h0005_0000, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        check("clr_busy", {63'd0, busy}, 64'd0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h0001_0000, 1'b0, 1'b0);
        idle(2);
        check("clr_pulses", pulses, 1);
        check("clr_sum", {32'd0, last_sum}, 64'h0003_0000);

        // clr and in_valid together: term dropped
        pulses = 0;
        cycle(1'b1, 32'h0001_0000, 1'b0, 1'b0);
        cycle(1'b1, 32'h0001_0000, 1'b0, 1'b0);
        cycle(1'b1, 32'h0001_0000, 1'b1, 1'b0);
        check("clrwin_no_pulse", pulses, 0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h0002_0000, 1'b0, 1'b0);
        idle(1);
        check("clrwin_sum", {32'd0, last_sum}, 64'h0006_0000);

        // clr right after the third term keeps the pending pulse
        pulses = 0;
        cycle(1'b1, 32'h0001_0000, 1'b0, 1'b0);
        cycle(1'b1, 32'h0001_0000, 1'b0, 1'b0);
        cycle(1'b1, 32'h0001_0000, 1'b0, 1'b0);
        cycle(1'b1, 32'h0004_0000, 1'b1, 1'b0);
        check("clr_after_e2_pulses", pulses, 1);
        check("clr_after_e2_sum", {32'd0, last_sum}, 64'h0003_0000);

        // rst after one term, then three -1.0 terms
        pulses = 0;
        cycle(1'b1, 32'h0001_0000, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        check("rst_mid_pulses", pulses, 0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'hFFFF_0000, 1'b0, 1'b0);
        idle(1);
        check("rst_mid_pulse_count", pulses, 1);
        check("rst_mid_sum", {32'd0, last_sum}, 64'hFFFD_0000);

        // rst together with the third term cancels the pulse
        pulses = 0;
        cycle(1'b1, 32'h0001_0000, 1'b0, 1'b0);
        cycle(1'b1, 32'h0001_0000, 1'b0, 1'b0);
        cycle(1'b1, 32'h0001_0000, 1'b0, 1'b1);
        idle(2);
        check("rst_e2_no_pulse", pulses, 0);

        // Six back-to-back 0.5 terms: pulses on cycles 4 and 7 from the first term
        pulses = 0;
        for (int i = 1; i <= 7; i++) begin
            cycle(i <= 6, 32'h0000_8000, 1'b0, 1'b0);
            check("six_pulse_timing", {63'd0, out_valid}, {63'd0, (i == 3 || i == 6)});
            if (out_valid) check("six_sum", {32'd0, sum}, 64'h0001_8000);
        end
        check("six_pulses", pulses, 2);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [31:0] p;
            case ($urandom_range(0, 3))
                0:       p = 32'h7FFF_FFFF - $urandom_range(0, 65535);
                1:       p = 32'h8000_0000 + $urandom_range(0, 65535);
                default: p = $urandom;
            endcase
            cycle($urandom_range(0, 2) != 0, p,
                  $urandom_range(0, 24) == 0, $urandom_range(0, 79) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/dot3_accum.md
DOT3_ACCUM -- requirements
Module: dot3_accum

Interface
REQ-001 The block SHALL use one clock and one reset: a single clock domain; reset is synchronous and active-high.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: in_valid  input  1  prod carries a valid product term this cycle.
REQ-005 Port: prod  input  fixedpoint::number  product term from the upstream fixed-point multiplier stage.
REQ-006 Port: clr  input  1  synchronous abort that discards any partial group.
REQ-007 Port: sum  output  fixedpoint::number  saturated sum of three consecutive product terms.
REQ-008 Port: out_valid  output  1  single-cycle pulse marking sum valid.
REQ-009 Port: overflow  output  1  the sum was saturated; meaningful only while out_valid is high.
REQ-010 Port: busy  output  1  a group is partially accumulated (element counter is non-zero).

Function
REQ-011 fixedpoint::number SHALL be signed two's complement Q16.16, 32 bits wide.
REQ-012 The state machine SHALL have three states:
- E0: expecting x term.
- E1: expecting y term.
- E2: expecting z term.
REQ-013 State transitions SHALL occur only on in_valid=1 and follow E0->E1->E2->E0; with in_valid=0 the state and accumulator SHALL hold.
REQ-014 Accumulator loading in each state:
- In E0, an accepted term SHALL load the accumulator with the term sign-extended to 34 bits.
- In E1, an accepted term SHALL be added to the accumulator.
- In E2, the accepted term SHALL be added and the result registered to the outputs.
REQ-015 The final sum SHALL be computed in 34 bits; results above 0x7FFF_FFFF SHALL saturate to 0x7FFF_FFFF and results below 0x8000_0000 SHALL saturate to 0x8000_0000, with overflow=1 in either case.
REQ-016 out_valid SHALL assert exactly one cycle after the E2 term is accepted and SHALL last exactly one cycle.
REQ-017 While out_valid=0, sum and overflow SHALL be driven to 0.
REQ-018 Throughput SHALL be one term per cycle with no bubble; a term accepted in the same cycle that out_valid is high SHALL start a new group in E0.
REQ-019 Gaps of any length between terms SHALL NOT affect the result.
REQ-020 clr=1 SHALL return the state to E0 and zero the accumulator; when clr and in_valid are both high, clr SHALL win and the term SHALL be dropped.
REQ-021 clr asserted in the cycle after an E2 acceptance SHALL NOT suppress the pending out_valid pulse.
REQ-022 busy SHALL be 1 in E1 and E2 and 0 in E0.

Reset
REQ-023 On rst=1 the block SHALL go to state E0 with accumulator=0, sum=0, out_valid=0, overflow=0 and busy=0.
REQ-024 rst SHALL take priority over clr and in_valid.
REQ-025 rst asserted mid-group SHALL discard the partial group and SHALL cancel any pending output pulse.

Structure
REQ-026 The fixedpoint package SHALL hold:
- the number typedef;
- WIDTH=32 and FRAC=16;
- the MAX and MIN constants;
- a sat_add function.
REQ-027 No sub-module is needed; the state machine and the single registered output stage are implemented inline, totalling two registered pipeline points (accumulator, output).

Verification
REQ-028 Terms 0x0001_0000, 0x0002_0000, 0x0003_0000 on back-to-back cycles -> one cycle after the third term, out_valid=1, sum=0x0006_0000, overflow=0.
REQ-029 The same three terms separated by 2 and 5 idle cycles -> a single out_valid pulse with sum=0x0006_0000; busy=1 only between the first and third terms.
REQ-030 Three terms of 0x7FFF_0000 -> sum=0x7FFF_FFFF, overflow=1; three terms of 0x8000_0000 -> sum=0x8000_0000, overflow=1.
REQ-031 Two terms of 0x0005_0000, then clr, then three terms of 0x0001_0000 -> exactly one pulse, with sum=0x0003_0000.
REQ-032 rst after one accepted term, then three terms of 0xFFFF_0000 (-1.0) -> sum=0xFFFD_0000 and no earlier pulse.
REQ-033 Six consecutive terms of 0x0000_8000 (0.5) -> two pulses, each with sum=0x0001_8000, on cycles 4 and 7 counted from the first term.
